// File: rtl/load_number_fifo.sv
// load_number_fifo: DEPTH-entry circular buffer between the stimulus driver's
// load strobe and a valid/ready consumer. Registered outputs only: a word
// written into an empty buffer appears on out_data one cycle later (no bypass).
// Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two
// (supported range 2..15, bounded by the 4-bit count port).
module load_number_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] number,
  input  logic             clear,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       count,
  output logic             full,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [3:0]    DEPTH_C  = 4'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [3:0]       count_q;
  logic             overflow_q;

  logic push;
  logic pop;
  logic drop;

  // Pointer increment with explicit wrap; the pointer never holds DEPTH.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Output decode from registered state only, so load/number never reach an output.
  always_comb begin
    out_valid = (count_q != 4'd0);
    full      = (count_q == DEPTH_C);
    count     = count_q;
    overflow  = overflow_q;
    out_data  = out_valid ? mem[rd_ptr] : '0;
  end

  // Handshake decode: a full buffer still accepts a word when the head leaves this cycle.
  always_comb begin
    pop  = out_valid & out_ready;
    push = load & (~full | pop);
    drop = load & full & ~pop;
  end

  // Pointer, occupancy and sticky overflow state; clear outranks push and pop.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage write; a load coinciding with clear is discarded.
  // NOTE: storage has no reset; out_data is masked by out_valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= number;
  end

endmodule

// File: tb/tb_load_number_fifo.sv
// Testbench for load_number_fifo: directed scenarios followed by randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_load_number_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] number = '0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       count;
  logic             full;
  logic             overflow;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model: the buffer contents in order plus the sticky flag.
  byte unsigned m_q[$];
  bit           m_ovf = 1'b0;

  load_number_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .number(number), .clear(clear),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against what the model says should be visible now.
  task automatic check_state(input string tag);
    int sz;
    sz = m_q.size();
    check({tag, "_valid"}, int'(out_valid), int'(sz != 0));
    check({tag, "_data"},  int'(out_data),  (sz != 0) ? int'(m_q[0]) : 0);
    check({tag, "_count"}, int'(count),     sz);
    check({tag, "_full"},  int'(full),      int'(sz == DEPTH));
    check({tag, "_ovf"},   int'(overflow),  int'(m_ovf));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then compare.
  task automatic cycle(input bit l, input byte unsigned n, input bit r, input bit c,
                       input string tag);
    bit was_full, do_pop, do_push;
    load = l; number = n; out_ready = r; clear = c;
    @(posedge clk);
    #1;
    if (c) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      do_pop   = r && (m_q.size() != 0);
      do_push  = l && (!was_full || do_pop);
      if (l && !do_push) m_ovf = 1'b1;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(n);
    end
    load = 1'b0; clear = 1'b0; out_ready = 1'b0;
    check_state(tag);
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data",  int'(out_data),  0);
    check("rst_count", int'(count),     0);
    check("rst_full",  int'(full),      0);
    check("rst_ovf",   int'(overflow),  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic order.
    cycle(1, 8'h11, 0, 0, "basic");
    check("basic_first_visible", int'(out_data), 'h11);
    cycle(1, 8'h22, 0, 0, "basic");
    cycle(1, 8'h33, 0, 0, "basic");
    check("basic_cnt3", int'(count), 3);
    check("basic_head", int'(out_data), 'h11);
    for (int i = 0; i < 3; i++) begin
      check("basic_order", int'(out_data), 'h11 * (i + 1));
      cycle(0, 8'h00, 1, 0, "basic_pop");
    end
    check("basic_empty", int'(out_valid), 0);

    // Fill and overflow.
    for (int i = 1; i <= 5; i++) cycle(1, byte'(i), 0, 0, "fill");
    check("fill_full", int'(full), 1);
    cycle(1, 8'h06, 0, 0, "ovf");
    check("ovf_flag", int'(overflow), 1);
    check("ovf_cnt", int'(count), 5);
    for (int i = 1; i <= 5; i++) begin
      check("ovf_drain", int'(out_data), i);
      cycle(0, 8'h00, 1, 0, "ovf_drain");
    end
    check("ovf_sticky", int'(overflow), 1);

    // Simultaneous push and pop at full.
    cycle(0, 8'h00, 0, 1, "clr0");
    for (int i = 0; i < 5; i++) cycle(1, byte'(8'hA0 + i), 0, 0, "fullpp_fill");
    cycle(1, 8'hA5, 1, 0, "fullpp");
    check("fullpp_cnt", int'(count), 5);
    check("fullpp_ovf", int'(overflow), 0);
    for (int i = 1; i <= 5; i++) begin
      check("fullpp_drain", int'(out_data), 'hA0 + i);
      cycle(0, 8'h00, 1, 0, "fullpp_drain");
    end

    // Wrap-around streaming.
    for (int i = 0; i < 12; i++) begin
      cycle(1, byte'(i), 1, 0, "wrap");
      check("wrap_word", int'(out_data), i);
      check("wrap_cnt_le1", int'(count <= 4'd1), 1);
    end
    cycle(0, 8'h00, 1, 0, "wrap_tail");

    // Clear priority with count=3 and overflow set.
    for (int i = 0; i < 6; i++) cycle(1, byte'(8'h40 + i), 0, 0, "clrp_fill");
    cycle(0, 8'h00, 1, 0, "clrp_pop");
    cycle(0, 8'h00, 1, 0, "clrp_pop");
    check("clrp_pre_cnt", int'(count), 3);
    check("clrp_pre_ovf", int'(overflow), 1);
    cycle(1, 8'h77, 0, 1, "clrp");
    check("clrp_cnt", int'(count), 0);
    check("clrp_ovf", int'(overflow), 0);
    check("clrp_valid", int'(out_valid), 0);
    cycle(0, 8'h00, 1, 0, "clrp_after");

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 4; i++) cycle(1, byte'(8'h90 + i), 0, 0, "arst_fill");
    check("arst_pre_cnt", int'(count), 4);
    #3;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_ovf = 1'b0;
    check("arst_valid", int'(out_valid), 0);
    check("arst_data",  int'(out_data),  0);
    check("arst_count", int'(count),     0);
    check("arst_full",  int'(full),      0);
    check("arst_ovf",   int'(overflow),  0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'h5A, 0, 0, "arst_rel");
    check("arst_rel_data", int'(out_data), 'h5A);
    cycle(0, 8'h00, 1, 0, "arst_rel_pop");

    // Randomized traffic with changing load/ready bias.
    for (int seg = 0; seg < 8; seg++) begin
      int lp, rp;
      lp = (seg % 2 == 0) ? 80 : 40;
      rp = (seg % 4 < 2) ? 30 : 75;
      for (int k = 0; k < 80; k++) begin
        cycle($urandom_range(99) < lp, byte'($urandom_range(255)),
              $urandom_range(99) < rp, $urandom_range(59) == 0, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/load_number_fifo.md
# load_number_fifo

Buffers the 8-bit `number` words that the stimulus driver presents with its `load` strobe and hands them, in order, to the downstream consumer over a valid/ready handshake. The block is the direct downstream stage of the stimulus driver. It decouples the driver's timed load bursts from a consumer that can stall. Storage is a 5-entry circular buffer with explicit pointer wrap. A sticky overflow flag records any word dropped because the buffer was full.

## Interface
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 5, number of entries. Need not be a power of two. Range 2..15.
- `clk` input 1: single clock. All state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `load` input 1: write strobe from the stimulus driver, one word per high cycle.
- `number` input WIDTH: write data, sampled when `load`=1.
- `clear` input 1: synchronous flush.
- `out_ready` input 1: consumer accepts the head word this cycle.
- `out_valid` output 1: head word present.
- `out_data` output WIDTH: head word; meaningful only while `out_valid`=1.
- `count` output 4: current occupancy, 0..DEPTH.
- `full` output 1: `count`==DEPTH.
- `overflow` output 1: sticky; a `load` was dropped.

## Operation
- State: storage array[DEPTH], `wr_ptr`, `rd_ptr`, `count`, `overflow`.
- Both pointers range 0..DEPTH-1. A pointer at DEPTH-1 wraps to 0 on increment; it never reaches DEPTH.
- Push: occurs when `load`=1 and either `full`=0, or `full`=1 with a pop in the same cycle.
  - Writes `number` at `wr_ptr`, then advances `wr_ptr`.
- Pop: occurs when `out_valid`=1 and `out_ready`=1.
  - Advances `rd_ptr`.
  - `out_ready` while `out_valid`=0 has no effect.
- Count update:
  - `count` +1 on push only.
  - `count` −1 on pop only.
  - `count` unchanged on push and pop together.
- Overflow: `load`=1 with `full`=1 and no pop drops the word. Storage, pointers and `count` are unchanged. `overflow` is set to 1.
  - `overflow` is cleared only by `rst_n` low or by `clear`.
- Clear: `clear`=1 zeroes both pointers, `count` and `overflow`.
  - `clear` has priority over push and pop in the same cycle; a simultaneous `load` is discarded and does not set `overflow`.
  - Storage contents are not cleared.
- Output drive:
  - `out_valid` = (`count`!=0).
  - `out_data` = array[`rd_ptr`] while `out_valid`=1, otherwise 0.
  - `full` is decoded from `count`.
- Empty case: no bypass. A word loaded into an empty buffer is not visible at the output until the following cycle.
- Reset, asserted at any time including mid-burst: immediately forces `wr_ptr`=0, `rd_ptr`=0, `count`=0, `overflow`=0.
  - Reset values of outputs: `out_valid`=0, `out_data`=0, `full`=0, `count`=0, `overflow`=0.
  - Storage array is not reset.
- Reset release: behaves like an empty buffer. The first `load` is accepted on the first rising edge with `rst_n`=1.

## Timing
- Write-to-read latency is 1 cycle. `load` sampled at edge N gives `out_valid`=1 with that word on `out_data` after edge N.
- Pop at edge N presents the next word, or deasserts `out_valid`, after edge N.
- `count`, `full` and `overflow` update at the same edge as the push or pop that causes them.
- Combinational paths:
  - No combinational path from `load`/`number` to any output.
  - `out_ready` influences only next-state logic.
- Throughput: one push and one pop per cycle sustained, including at `full`.

## Test plan
- **Basic order.** After reset, load 0x11, 0x22, 0x33 on consecutive cycles with `out_ready`=0 → `count`=3, `out_data`=0x11. Then raise `out_ready` for 3 cycles → outputs 0x11, 0x22, 0x33 in order, then `out_valid`=0 and `count`=0.
- **Fill and overflow.** Load 0x01..0x05 → `full`=1. Load 0x06 with `out_ready`=0 → `overflow`=1, `count`=5. Then drain 5 → 0x01..0x05 in order; 0x06 never appears; `overflow` stays 1.
- **Simultaneous push/pop at full.**
  - Full with 0xA0..0xA4, then `load` 0xA5 with `out_ready`=1 → 0xA0 popped, `count` stays 5, `overflow`=0.
  - Drain → 0xA1..0xA5.
- **Wrap-around.** Stream 12 words 0x00..0x0B with `out_ready`=1 throughout (`count` never exceeds 1) → all 12 appear in order, 1 cycle after load. Both pointers wrap at DEPTH=5 (twice over 12 words).
- **Clear priority.** With `count`=3 and `overflow`=1, assert `clear` together with `load` 0x77 → `count`=0, `overflow`=0, `out_valid`=0. 0x77 is never output.
- **Async reset mid-operation.** With `count`=4, drop `rst_n` between clock edges → all outputs go to reset values without waiting for an edge. After release, load 0x5A → `out_data`=0x5A one cycle later.
